// File: rtl/snn_pkg.sv
// ============================================================================
// snn_pkg : packet field layout, opcodes and stage states shared by the SNN pipe
// Revision : 1.0
// ============================================================================
`default_nettype none

package snn_pkg;

   localparam int PKT_W        = 33;
   localparam int ADDR_START   = 29;
   localparam int ADDR_END     = 32;
   localparam int OPCODE_START = 25;
   localparam int OPCODE_END   = 28;
   localparam int DATA_START   = 0;
   localparam int DATA_END     = 24;
   localparam int DATA_W       = DATA_END - DATA_START + 1;

   // Offsets inside the data field of a PSUM packet
   localparam int IDX_START    = 20;
   localparam int PSUM_START   = 0;

   typedef enum logic [3:0] {
      OP_WEIGHT   = 4'd0,
      OP_INPUT    = 4'd1,
      OP_PSUM     = 4'd2,
      OP_SPIKE    = 4'd3,
      OP_TIMESTEP = 4'd15
   } opcode_e;

   typedef logic [PKT_W-1:0] packet_t;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      SCAN   = 2'd1,
      EMIT   = 2'd2,
      CLEAR  = 2'd3
   } state_e;

   function automatic packet_t make_packet(input logic [3:0] addr,
                                           input opcode_e op,
                                           input logic [DATA_W-1:0] data);
      return {addr, op, data};
   endfunction

endpackage

`default_nettype wire

// File: rtl/membrane_bank.sv
// ============================================================================
// membrane_bank : per-neuron membrane registers, saturating add port and
//                 threshold-subtract / clear port. Revision : 1.0
// ============================================================================
`default_nettype none

module membrane_bank #(
   parameter int NUM_NEURONS = 21,
   parameter int IDX_W       = 5,
   parameter int PSUM_W      = 13,
   parameter int MEM_W       = 16,
   parameter int THRESH      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              add_en,
   input  logic [IDX_W-1:0]  add_idx,
   input  logic [PSUM_W-1:0] add_val,
   input  logic              scan_en,
   input  logic [IDX_W-1:0]  scan_idx,
   input  logic              clear,
   output logic              fire
);

   logic [MEM_W-1:0]       mem     [NUM_NEURONS];
   logic [MEM_W-1:0]       add_sum [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] add_hit;
   logic [NUM_NEURONS-1:0] sub_hit;

   for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
      logic [MEM_W:0] sum_wide;

      assign add_hit[i]  = add_en && (add_idx == IDX_W'(i));
      // One extra bit catches the carry so the sum clamps at all-ones
      assign sum_wide    = {1'b0, mem[i]} + (MEM_W+1)'(add_val);
      assign add_sum[i]  = sum_wide[MEM_W] ? {MEM_W{1'b1}} : sum_wide[MEM_W-1:0];
      assign sub_hit[i]  = scan_en && (scan_idx == IDX_W'(i)) &&
                           (mem[i] >= MEM_W'(THRESH));
   end

   assign fire = |sub_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (clear) begin
               mem[i] <= '0;
            end else if (add_hit[i]) begin
               mem[i] <= add_sum[i];
            end else if (sub_hit[i]) begin
               mem[i] <= mem[i] - MEM_W'(THRESH);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/psum_spike_accumulator.sv
// ============================================================================
// psum_spike_accumulator : accumulates ppe partial sums into membranes, emits one
//                          spike bitmap per timestep. Revision : 1.0
// ============================================================================
`default_nettype none

module psum_spike_accumulator
   import snn_pkg::*;
#(
   parameter int         NUM_NEURONS   = 21,
   parameter int         IDX_W         = 5,
   parameter int         PSUM_W        = 13,
   parameter int         MEM_W         = 16,
   parameter int         THRESH        = 64,
   parameter int         NUM_TIMESTEPS = 10,
   parameter logic [3:0] OUT_ADDR      = 4'd9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [32:0]   in_packet,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [32:0]   out_packet,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    timestep_idx,
   output logic [7:0]    drop_count
);

   state_e                 state;
   state_e                 state_nxt;
   logic [IDX_W-1:0]       scan_ptr;
   logic [NUM_NEURONS-1:0] spike_vec;

   logic [3:0]             opcode;
   logic [IDX_W-1:0]       idx;
   logic [PSUM_W-1:0]      psum;
   logic                   accept;
   logic                   idx_ok;
   logic                   add_en;
   logic                   drop;
   logic                   ts_accept;
   logic                   scan_last;
   logic                   emit_done;
   logic                   fire;
   logic [3:0]             ts_next;
   logic                   unused_fields;

   assign opcode    = in_packet[OPCODE_END:OPCODE_START];
   assign idx       = in_packet[DATA_START+IDX_START +: IDX_W];
   assign psum      = in_packet[DATA_START+PSUM_START +: PSUM_W];
   assign unused_fields = ^{in_packet[ADDR_END:ADDR_START],
                            in_packet[DATA_START+IDX_START-1:DATA_START+PSUM_W]};

   assign accept    = in_valid && in_ready;
   assign idx_ok    = idx < IDX_W'(NUM_NEURONS);
   assign add_en    = accept && (opcode == OP_PSUM) && idx_ok;
   assign ts_accept = accept && (opcode == OP_TIMESTEP);
   assign drop      = accept && !add_en && !ts_accept;
   assign scan_last = scan_ptr == IDX_W'(NUM_NEURONS-1);
   assign emit_done = (state == EMIT) && out_valid && out_ready;
   assign ts_next   = timestep_idx + 4'd1;

   membrane_bank #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_W       (IDX_W),
      .PSUM_W      (PSUM_W),
      .MEM_W       (MEM_W),
      .THRESH      (THRESH)
   ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .add_en   (add_en),
      .add_idx  (idx),
      .add_val  (psum),
      .scan_en  (state == SCAN),
      .scan_idx (scan_ptr),
      .clear    (state == CLEAR),
      .fire     (fire)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ACCEPT: begin
            in_ready = 1'b1;
            if (ts_accept) state_nxt = SCAN;
         end
         SCAN: begin
            if (scan_last) state_nxt = EMIT;
         end
         EMIT: begin
            if (emit_done) state_nxt = (ts_next == 4'(NUM_TIMESTEPS)) ? CLEAR : ACCEPT;
         end
         CLEAR: begin
            state_nxt = ACCEPT;
         end
         default: state_nxt = ACCEPT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ACCEPT;
         scan_ptr     <= '0;
         spike_vec    <= '0;
         out_valid    <= 1'b0;
         out_packet   <= '0;
         timestep_idx <= '0;
         drop_count   <= '0;
      end else begin
         state <= state_nxt;

         if (ts_accept) begin
            scan_ptr  <= '0;
            spike_vec <= '0;
         end else if (state == SCAN) begin
            scan_ptr <= scan_ptr + IDX_W'(1);
            if (fire) spike_vec <= spike_vec | (NUM_NEURONS'(1) << scan_ptr);
         end

         // The bitmap is registered on the first EMIT cycle, once the last
         // scan write to spike_vec has landed.
         if ((state == EMIT) && !out_valid) begin
            out_valid  <= 1'b1;
            out_packet <= make_packet(OUT_ADDR, OP_SPIKE, DATA_W'(spike_vec));
         end else if (emit_done) begin
            out_valid  <= 1'b0;
         end

         if (emit_done) begin
            timestep_idx <= ts_next;
         end else if (state == CLEAR) begin
            timestep_idx <= '0;
         end

         if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

`default_nettype wire
